div_sequencer: RTL and testbench

Multi-cycle divide sequencer for the E stage. Accepts DIV/DIVU operands from the execute stage and runs a 32-iteration radix-2 restoring divide. Drives `div_stallE` into the hazard unit, which holds F/D/E while the divide is in flight. Delivers HI/LO results with a one-cycle ready pulse on the cycle the E stage is released.

---
 rtl/div_sequencer.sv | 162 ++++++++++++++++
 tb/tb_div_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : div_sequencer
// Description : Radix-2 restoring DIV/DIVU sequencer for the E stage. It stalls
//               F/D/E while the divide runs and pulses ready when E is released.
//               Optional macro DIV_ZERO_BYPASS_EN: a zero divisor skips the
//               iterations and completes in one cycle.
// Revision    : 1.0 - initial release
// =============================================================================
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_startE,
    input  logic             div_signedE,
    input  logic [WIDTH-1:0] opaE,
    input  logic [WIDTH-1:0] opbE,
    input  logic             annulE,
    output logic             div_stallE,
    output logic             div_readyE,
    output logic [WIDTH-1:0] hiE,
    output logic [WIDTH-1:0] loE
);

    localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q,  rem_d;
    logic [WIDTH-1:0] quo_q,  quo_d;
    logic [WIDTH-1:0] divs_q, divs_d;
    logic [WIDTH-1:0] hi_q,   hi_d;
    logic [WIDTH-1:0] lo_q,   lo_d;
    logic             sa_q,   sa_d;
    logic             sb_q,   sb_d;
    logic             sgn_q,  sgn_d;
    logic [CW-1:0]    cnt_q,  cnt_d;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_lo_fix;
    logic [WIDTH-1:0] w_hi_fix;

    assign w_a_mag = (div_signedE & opaE[WIDTH-1]) ? -opaE : opaE;
    assign w_b_mag = (div_signedE & opbE[WIDTH-1]) ? -opbE : opbE;

    // The dividend sits in quo_q and is shifted into the remainder MSB first.
    // When the trial subtraction succeeds the true difference is below 2^WIDTH,
    // so the low WIDTH bits of the subtraction are exact.
    assign w_shift  = {rem_q, quo_q[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, divs_q});
    assign w_rem_nx = w_ge ? (w_shift[WIDTH-1:0] - divs_q) : w_shift[WIDTH-1:0];
    assign w_quo_nx = {quo_q[WIDTH-2:0], w_ge};
    assign w_lo_fix = (sgn_q & (sa_q ^ sb_q)) ? -w_quo_nx : w_quo_nx;
    assign w_hi_fix = (sgn_q & sa_q)          ? -w_rem_nx : w_rem_nx;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        divs_d  = divs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        if (annulE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_startE) begin
`ifdef DIV_ZERO_BYPASS_EN
                        if (opbE == '0) begin
                            hi_d    = opaE;
                            lo_d    = (div_signedE & opaE[WIDTH-1]) ? WIDTH'(1) : '1;
                            state_d = S_DONE;
                        end else begin
                            rem_d   = '0;
                            cnt_d   = '0;
                            quo_d   = w_a_mag;
                            divs_d  = w_b_mag;
                            sa_d    = opaE[WIDTH-1];
                            sb_d    = opbE[WIDTH-1];
                            sgn_d   = div_signedE;
                            state_d = S_BUSY;
                        end
`else
                        rem_d   = '0;
                        cnt_d   = '0;
                        quo_d   = w_a_mag;
                        divs_d  = w_b_mag;
                        sa_d    = opaE[WIDTH-1];
                        sb_d    = opbE[WIDTH-1];
                        sgn_d   = div_signedE;
                        state_d = S_BUSY;
`endif
                    end
                end
                S_BUSY: begin
                    rem_d = w_rem_nx;
                    quo_d = w_quo_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == C_LAST) begin
                        hi_d    = w_hi_fix;
                        lo_d    = w_lo_fix;
                        state_d = S_DONE;
                    end
                end
                // The start seen in DONE belongs to the retiring instruction.
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            divs_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            divs_q  <= divs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
        end
    end

    assign div_stallE = ~rst & (((state_q == S_IDLE) & div_startE & ~annulE) |
                                (state_q == S_BUSY));
    assign div_readyE = ~rst & (state_q == S_DONE) & ~annulE;
    assign hiE        = hi_q;
    assign loE        = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : tb_div_sequencer
// Description : Directed, table-driven bench for div_sequencer (WIDTH = 32).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_div_sequencer;

`ifdef DIV_ZERO_BYPASS_EN
    localparam bit C_BYP = 1'b1;
`else
    localparam bit C_BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, sgn, annul;
    logic [31:0] a, b;
    logic        stall, ready;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t tbl[12];

    div_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_startE (start),
        .div_signedE(sgn),
        .opaE       (a),
        .opbE       (b),
        .annulE     (annul),
        .div_stallE (stall),
        .div_readyE (ready),
        .hiE        (hi),
        .loE        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a divide in the current cycle and holds start high through DONE,
    // returning at the cycle after DONE with start still asserted.
    task automatic run_div(input vec_t v, input string nm);
        int          rc;
        int          stalls;
        bit          changed;
        logic [31:0] plo, phi, rlo, rhi;
        int          exp_rc;
        plo     = lo;
        phi     = hi;
        rlo     = '0;
        rhi     = '0;
        rc      = -1;
        stalls  = 0;
        changed = 1'b0;
        exp_rc  = (C_BYP && v.b == 32'd0) ? 1 : 33;
        start = 1'b1;
        sgn   = v.sgn;
        a     = v.a;
        b     = v.b;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (stall) stalls++;
            if (ready && rc < 0) begin
                rc  = c;
                rlo = lo;
                rhi = hi;
            end else if (lo !== plo || hi !== phi) begin
                changed = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rc >= 0) break;
        end
        chk({nm, "_latency"}, 32'(rc), 32'(exp_rc));
        chk({nm, "_stalls"}, 32'(stalls), 32'(exp_rc));
        chk({nm, "_lo"}, rlo, v.lo);
        chk({nm, "_hi"}, rhi, v.hi);
        chk({nm, "_hold"}, 32'(changed), 32'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        tbl[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        tbl[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        tbl[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
        tbl[5]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'd1,          32'hFFFF_FFFB};
        tbl[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        tbl[7]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        tbl[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
        tbl[9]  = '{1'b0, 32'h1234_5678,  32'h0000_1000,  32'h0001_2345,  32'h0000_0678};
        tbl[10] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3};
        tbl[11] = '{1'b1, 32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF};

        rst = 1'b1; start = 1'b0; sgn = 1'b0; annul = 1'b0; a = '0; b = '0;
        tick(); tick();
        start = 1'b1; a = 32'd9; b = 32'd3;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_hi", hi, 32'd0);
        tick();
        rst = 1'b0; start = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_div(tbl[i], $sformatf("vec%0d", i));
            start = 1'b0;
            #1;
            chk($sformatf("vec%0d_post_stall", i), 32'(stall), 32'd0);
            chk($sformatf("vec%0d_post_ready", i), 32'(ready), 32'd0);
            tick();
        end

        // Back-to-back: second divide enters E the cycle after DONE.
        run_div('{1'b0, 32'd100,  32'd7,  32'd14,  32'd2}, "b2b_first");
        run_div('{1'b0, 32'd1000, 32'd10, 32'd100, 32'd0}, "b2b_second");
        start = 1'b0;
        tick();

        // Annul in cycle 10 of an in-flight divide.
        begin
            logic [31:0] plo, phi;
            bit          seen;
            plo = lo; phi = hi; seen = 1'b0;
            start = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
            for (int c = 0; c < 10; c++) tick();
            annul = 1'b1;
            #1;
            chk("annul_stall_k", 32'(stall), 32'd1);
            tick();
            annul = 1'b0; start = 1'b0;
            #1;
            chk("annul_stall_k1", 32'(stall), 32'd0);
            for (int c = 0; c < 40; c++) begin
                if (ready) seen = 1'b1;
                tick();
            end
            chk("annul_no_ready", 32'(seen), 32'd0);
            chk("annul_lo_kept", lo, plo);
            chk("annul_hi_kept", hi, phi);
        end

        // Reset mid-divide.
        start = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b1;
        #1;
        chk("midrst_stall_forced", 32'(stall), 32'd0);
        tick();
        rst = 1'b0; start = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
